// File: rtl/cache_axi_arbiter_pkg.sv
// Shared constants for the cache-to-AXI3 arbiter:
// FSM encodings, AXI attribute values and the latched request bundle.
package cache_axi_arbiter_pkg;

  localparam int ID_W = 4;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_ADDR = 2'd1;
  localparam logic [1:0] W_DATA = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] LOCK_NORMAL = 2'b00;
  localparam logic [3:0] CACHE_NONE  = 4'b0000;
  localparam logic [2:0] PROT_NONE   = 3'b000;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } axi_req_t;

endpackage

// File: rtl/cache_axi_arbiter.sv
// Merges icache reads and dcache reads/writes onto one AXI3 master.
// Read and write FSMs run concurrently; dcache reads wait for writes.
module cache_axi_arbiter
  import cache_axi_arbiter_pkg::*;
#(
  parameter logic [ID_W-1:0] ID_INST = 4'd0,
  parameter logic [ID_W-1:0] ID_DATA = 4'd1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_inst_ar_valid,
  output logic            io_inst_ar_ready,
  input  logic [31:0]     io_inst_ar_addr,
  input  logic [7:0]      io_inst_ar_len,
  input  logic [2:0]      io_inst_ar_size,
  output logic            io_inst_r_valid,
  input  logic            io_inst_r_ready,
  output logic [31:0]     io_inst_r_data,
  output logic            io_inst_r_last,
  input  logic            io_data_ar_valid,
  output logic            io_data_ar_ready,
  input  logic [31:0]     io_data_ar_addr,
  input  logic [7:0]      io_data_ar_len,
  input  logic [2:0]      io_data_ar_size,
  output logic            io_data_r_valid,
  input  logic            io_data_r_ready,
  output logic [31:0]     io_data_r_data,
  output logic            io_data_r_last,
  input  logic            io_data_aw_valid,
  output logic            io_data_aw_ready,
  input  logic [31:0]     io_data_aw_addr,
  input  logic [7:0]      io_data_aw_len,
  input  logic [2:0]      io_data_aw_size,
  input  logic            io_data_w_valid,
  output logic            io_data_w_ready,
  input  logic [31:0]     io_data_w_data,
  input  logic [3:0]      io_data_w_strb,
  input  logic            io_data_w_last,
  output logic            io_data_b_valid,
  input  logic            io_data_b_ready,
  output logic            io_axi_ar_valid,
  input  logic            io_axi_ar_ready,
  output logic [ID_W-1:0] io_axi_ar_id,
  output logic [31:0]     io_axi_ar_addr,
  output logic [7:0]      io_axi_ar_len,
  output logic [2:0]      io_axi_ar_size,
  output logic [1:0]      io_axi_ar_burst,
  output logic [1:0]      io_axi_ar_lock,
  output logic [3:0]      io_axi_ar_cache,
  output logic [2:0]      io_axi_ar_prot,
  input  logic            io_axi_r_valid,
  output logic            io_axi_r_ready,
  input  logic [ID_W-1:0] io_axi_r_id,
  input  logic [31:0]     io_axi_r_data,
  input  logic [1:0]      io_axi_r_resp,
  input  logic            io_axi_r_last,
  output logic            io_axi_aw_valid,
  input  logic            io_axi_aw_ready,
  output logic [ID_W-1:0] io_axi_aw_id,
  output logic [31:0]     io_axi_aw_addr,
  output logic [7:0]      io_axi_aw_len,
  output logic [2:0]      io_axi_aw_size,
  output logic [1:0]      io_axi_aw_burst,
  output logic [1:0]      io_axi_aw_lock,
  output logic [3:0]      io_axi_aw_cache,
  output logic [2:0]      io_axi_aw_prot,
  output logic            io_axi_w_valid,
  input  logic            io_axi_w_ready,
  output logic [ID_W-1:0] io_axi_w_id,
  output logic [31:0]     io_axi_w_data,
  output logic [3:0]      io_axi_w_strb,
  output logic            io_axi_w_last,
  input  logic            io_axi_b_valid,
  output logic            io_axi_b_ready,
  input  logic [ID_W-1:0] io_axi_b_id,
  input  logic [1:0]      io_axi_b_resp
);

  logic [1:0] r_rstate;
  logic [1:0] r_wstate;
  logic       r_rr_data;
  logic       r_owner_data;
  axi_req_t   r_ar;
  axi_req_t   r_aw;

  logic w_data_elig;
  logic w_r_idle;
  logic w_grant_data;
  logic w_grant_inst;
  logic w_r_data;
  logic w_w_data;
  logic w_r_done;
  logic w_unused;

  // Responses and ids are not inspected; routing uses the latched owner.
  assign w_unused = ^{io_axi_r_id, io_axi_r_resp,
                      io_axi_b_id, io_axi_b_resp};

  assign w_data_elig  = io_data_ar_valid && (r_wstate == W_IDLE);
  assign w_r_idle     = !reset && (r_rstate == R_IDLE);
  assign w_grant_data = w_r_idle && w_data_elig &&
                        (!io_inst_ar_valid || r_rr_data);
  assign w_grant_inst = w_r_idle && io_inst_ar_valid && !w_grant_data;
  assign w_r_data     = !reset && (r_rstate == R_DATA);
  assign w_w_data     = !reset && (r_wstate == W_DATA);
  assign w_r_done     = io_axi_r_valid && io_axi_r_ready && io_axi_r_last;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rstate     <= R_IDLE;
      r_rr_data    <= 1'b1;
      r_owner_data <= 1'b0;
      r_ar         <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_grant_data) begin
            r_rstate     <= R_ADDR;
            r_owner_data <= 1'b1;
            r_rr_data    <= 1'b0;
            r_ar         <= '{io_data_ar_addr, io_data_ar_len,
                              io_data_ar_size};
          end else if (w_grant_inst) begin
            r_rstate     <= R_ADDR;
            r_owner_data <= 1'b0;
            r_rr_data    <= 1'b1;
            r_ar         <= '{io_inst_ar_addr, io_inst_ar_len,
                              io_inst_ar_size};
          end
        end
        R_ADDR: if (io_axi_ar_ready) r_rstate <= R_DATA;
        R_DATA: if (w_r_done) r_rstate <= R_IDLE;
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wstate <= W_IDLE;
      r_aw     <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: if (io_data_aw_valid) begin
          r_wstate <= W_ADDR;
          r_aw     <= '{io_data_aw_addr, io_data_aw_len,
                        io_data_aw_size};
        end
        W_ADDR: if (io_axi_aw_ready) r_wstate <= W_DATA;
        W_DATA: if (io_data_w_valid && io_axi_w_ready &&
                    io_data_w_last) r_wstate <= W_RESP;
        W_RESP: if (io_axi_b_valid && io_data_b_ready)
          r_wstate <= W_IDLE;
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  assign io_inst_ar_ready = w_grant_inst;
  assign io_data_ar_ready = w_grant_data;

  assign io_axi_ar_valid = !reset && (r_rstate == R_ADDR);
  assign io_axi_ar_id    = r_owner_data ? ID_DATA : ID_INST;
  assign io_axi_ar_addr  = r_ar.addr;
  assign io_axi_ar_len   = r_ar.len;
  assign io_axi_ar_size  = r_ar.size;
  assign io_axi_ar_burst = BURST_INCR;
  assign io_axi_ar_lock  = LOCK_NORMAL;
  assign io_axi_ar_cache = CACHE_NONE;
  assign io_axi_ar_prot  = PROT_NONE;

  assign io_axi_r_ready  = w_r_data &&
                           (r_owner_data ? io_data_r_ready
                                         : io_inst_r_ready);
  assign io_inst_r_valid = w_r_data && !r_owner_data && io_axi_r_valid;
  assign io_data_r_valid = w_r_data && r_owner_data && io_axi_r_valid;
  assign io_inst_r_data  = io_axi_r_data;
  assign io_inst_r_last  = io_axi_r_last;
  assign io_data_r_data  = io_axi_r_data;
  assign io_data_r_last  = io_axi_r_last;

  assign io_data_aw_ready = !reset && (r_wstate == W_IDLE);
  assign io_axi_aw_valid  = !reset && (r_wstate == W_ADDR);
  assign io_axi_aw_id     = ID_DATA;
  assign io_axi_aw_addr   = r_aw.addr;
  assign io_axi_aw_len    = r_aw.len;
  assign io_axi_aw_size   = r_aw.size;
  assign io_axi_aw_burst  = BURST_INCR;
  assign io_axi_aw_lock   = LOCK_NORMAL;
  assign io_axi_aw_cache  = CACHE_NONE;
  assign io_axi_aw_prot   = PROT_NONE;

  assign io_axi_w_valid  = w_w_data && io_data_w_valid;
  assign io_data_w_ready = w_w_data && io_axi_w_ready;
  assign io_axi_w_id     = ID_DATA;
  assign io_axi_w_data   = io_data_w_data;
  assign io_axi_w_strb   = io_data_w_strb;
  assign io_axi_w_last   = io_data_w_last;

  assign io_axi_b_ready  = !reset && (r_wstate == W_RESP) &&
                           io_data_b_ready;
  assign io_data_b_valid = !reset && (r_wstate == W_RESP) &&
                           io_axi_b_valid;

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed bench for cache_axi_arbiter: inputs change on the falling
// edge, outputs are sampled 1ns later, state moves on the rising edge.
module tb_cache_axi_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_inst_ar_valid = 0, io_inst_ar_ready;
  logic [31:0] io_inst_ar_addr = 0;
  logic [7:0]  io_inst_ar_len = 0;
  logic [2:0]  io_inst_ar_size = 0;
  logic        io_inst_r_valid, io_inst_r_ready = 0;
  logic [31:0] io_inst_r_data;
  logic        io_inst_r_last;
  logic        io_data_ar_valid = 0, io_data_ar_ready;
  logic [31:0] io_data_ar_addr = 0;
  logic [7:0]  io_data_ar_len = 0;
  logic [2:0]  io_data_ar_size = 0;
  logic        io_data_r_valid, io_data_r_ready = 0;
  logic [31:0] io_data_r_data;
  logic        io_data_r_last;
  logic        io_data_aw_valid = 0, io_data_aw_ready;
  logic [31:0] io_data_aw_addr = 0;
  logic [7:0]  io_data_aw_len = 0;
  logic [2:0]  io_data_aw_size = 0;
  logic        io_data_w_valid = 0, io_data_w_ready;
  logic [31:0] io_data_w_data = 0;
  logic [3:0]  io_data_w_strb = 0;
  logic        io_data_w_last = 0;
  logic        io_data_b_valid, io_data_b_ready = 0;
  logic        io_axi_ar_valid, io_axi_ar_ready = 0;
  logic [3:0]  io_axi_ar_id;
  logic [31:0] io_axi_ar_addr;
  logic [7:0]  io_axi_ar_len;
  logic [2:0]  io_axi_ar_size;
  logic [1:0]  io_axi_ar_burst, io_axi_ar_lock;
  logic [3:0]  io_axi_ar_cache;
  logic [2:0]  io_axi_ar_prot;
  logic        io_axi_r_valid = 0, io_axi_r_ready;
  logic [3:0]  io_axi_r_id = 0;
  logic [31:0] io_axi_r_data = 0;
  logic [1:0]  io_axi_r_resp = 0;
  logic        io_axi_r_last = 0;
  logic        io_axi_aw_valid, io_axi_aw_ready = 0;
  logic [3:0]  io_axi_aw_id;
  logic [31:0] io_axi_aw_addr;
  logic [7:0]  io_axi_aw_len;
  logic [2:0]  io_axi_aw_size;
  logic [1:0]  io_axi_aw_burst, io_axi_aw_lock;
  logic [3:0]  io_axi_aw_cache;
  logic [2:0]  io_axi_aw_prot;
  logic        io_axi_w_valid, io_axi_w_ready = 0;
  logic [3:0]  io_axi_w_id;
  logic [31:0] io_axi_w_data;
  logic [3:0]  io_axi_w_strb;
  logic        io_axi_w_last;
  logic        io_axi_b_valid = 0, io_axi_b_ready;
  logic [3:0]  io_axi_b_id = 0;
  logic [1:0]  io_axi_b_resp = 0;

  int n_checks = 0;
  int n_fail = 0;
  int aw_cnt = 0, w_cnt = 0, wl_cnt = 0, b_cnt = 0;

  wire [11:0] w_vr = {io_inst_ar_ready, io_data_ar_ready,
                      io_data_aw_ready, io_data_w_ready,
                      io_inst_r_valid, io_data_r_valid,
                      io_data_b_valid, io_axi_ar_valid,
                      io_axi_r_ready, io_axi_aw_valid,
                      io_axi_w_valid, io_axi_b_ready};

  cache_axi_arbiter dut (
    .clock(clock), .reset(reset),
    .io_inst_ar_valid(io_inst_ar_valid),
    .io_inst_ar_ready(io_inst_ar_ready),
    .io_inst_ar_addr(io_inst_ar_addr),
    .io_inst_ar_len(io_inst_ar_len),
    .io_inst_ar_size(io_inst_ar_size),
    .io_inst_r_valid(io_inst_r_valid),
    .io_inst_r_ready(io_inst_r_ready),
    .io_inst_r_data(io_inst_r_data),
    .io_inst_r_last(io_inst_r_last),
    .io_data_ar_valid(io_data_ar_valid),
    .io_data_ar_ready(io_data_ar_ready),
    .io_data_ar_addr(io_data_ar_addr),
    .io_data_ar_len(io_data_ar_len),
    .io_data_ar_size(io_data_ar_size),
    .io_data_r_valid(io_data_r_valid),
    .io_data_r_ready(io_data_r_ready),
    .io_data_r_data(io_data_r_data),
    .io_data_r_last(io_data_r_last),
    .io_data_aw_valid(io_data_aw_valid),
    .io_data_aw_ready(io_data_aw_ready),
    .io_data_aw_addr(io_data_aw_addr),
    .io_data_aw_len(io_data_aw_len),
    .io_data_aw_size(io_data_aw_size),
    .io_data_w_valid(io_data_w_valid),
    .io_data_w_ready(io_data_w_ready),
    .io_data_w_data(io_data_w_data),
    .io_data_w_strb(io_data_w_strb),
    .io_data_w_last(io_data_w_last),
    .io_data_b_valid(io_data_b_valid),
    .io_data_b_ready(io_data_b_ready),
    .io_axi_ar_valid(io_axi_ar_valid),
    .io_axi_ar_ready(io_axi_ar_ready),
    .io_axi_ar_id(io_axi_ar_id),
    .io_axi_ar_addr(io_axi_ar_addr),
    .io_axi_ar_len(io_axi_ar_len),
    .io_axi_ar_size(io_axi_ar_size),
    .io_axi_ar_burst(io_axi_ar_burst),
    .io_axi_ar_lock(io_axi_ar_lock),
    .io_axi_ar_cache(io_axi_ar_cache),
    .io_axi_ar_prot(io_axi_ar_prot),
    .io_axi_r_valid(io_axi_r_valid),
    .io_axi_r_ready(io_axi_r_ready),
    .io_axi_r_id(io_axi_r_id),
    .io_axi_r_data(io_axi_r_data),
    .io_axi_r_resp(io_axi_r_resp),
    .io_axi_r_last(io_axi_r_last),
    .io_axi_aw_valid(io_axi_aw_valid),
    .io_axi_aw_ready(io_axi_aw_ready),
    .io_axi_aw_id(io_axi_aw_id),
    .io_axi_aw_addr(io_axi_aw_addr),
    .io_axi_aw_len(io_axi_aw_len),
    .io_axi_aw_size(io_axi_aw_size),
    .io_axi_aw_burst(io_axi_aw_burst),
    .io_axi_aw_lock(io_axi_aw_lock),
    .io_axi_aw_cache(io_axi_aw_cache),
    .io_axi_aw_prot(io_axi_aw_prot),
    .io_axi_w_valid(io_axi_w_valid),
    .io_axi_w_ready(io_axi_w_ready),
    .io_axi_w_id(io_axi_w_id),
    .io_axi_w_data(io_axi_w_data),
    .io_axi_w_strb(io_axi_w_strb),
    .io_axi_w_last(io_axi_w_last),
    .io_axi_b_valid(io_axi_b_valid),
    .io_axi_b_ready(io_axi_b_ready),
    .io_axi_b_id(io_axi_b_id),
    .io_axi_b_resp(io_axi_b_resp)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (io_axi_aw_valid && io_axi_aw_ready) aw_cnt <= aw_cnt + 1;
    if (io_axi_w_valid && io_axi_w_ready) begin
      w_cnt <= w_cnt + 1;
      if (io_axi_w_last) wl_cnt <= wl_cnt + 1;
    end
    if (io_data_b_valid && io_data_b_ready) b_cnt <= b_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    io_inst_ar_valid = 0; io_data_ar_valid = 0;
    io_data_aw_valid = 0; io_data_w_valid = 0;
    io_data_w_last = 0; io_inst_r_ready = 0;
    io_data_r_ready = 0; io_data_b_ready = 0;
    io_axi_ar_ready = 0; io_axi_r_valid = 0;
    io_axi_r_last = 0; io_axi_aw_ready = 0;
    io_axi_w_ready = 0; io_axi_b_valid = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    clear_inputs();
    reset = 1;
    @(negedge clock);
    reset = 0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1;
    io_inst_ar_valid = 1; io_data_ar_valid = 1;
    io_data_aw_valid = 1; io_data_w_valid = 1;
    io_axi_r_valid = 1; io_axi_b_valid = 1;
    io_inst_r_ready = 1; io_data_b_ready = 1;
    @(negedge clock);
    #1;
    n_checks++;
    if (w_vr !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outs got=%h exp=000", w_vr);
    end
    clear_inputs();
    reset = 0;
    #1;
    n_checks++;
    if (w_vr !== 12'b0010_0000_0000) begin
      n_fail++;
      $display("FAIL reset_idle got=%b exp=001000000000", w_vr);
    end
  endtask

  task automatic test_inst_read();
    @(negedge clock);
    io_inst_ar_valid = 1; io_inst_ar_addr = 32'hBFC0_0000;
    io_inst_ar_len = 0; io_inst_ar_size = 3'd2;
    #1;
    n_checks++;
    if ({io_inst_ar_ready, io_data_ar_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL inst_grant got=%b exp=10",
               {io_inst_ar_ready, io_data_ar_ready});
    end
    @(negedge clock);
    io_inst_ar_valid = 0; io_axi_ar_ready = 1;
    #1;
    n_checks++;
    if ({io_axi_ar_valid, io_axi_ar_id, io_axi_ar_addr,
         io_axi_ar_len, io_axi_ar_size, io_axi_ar_burst,
         io_axi_ar_lock, io_axi_ar_cache, io_axi_ar_prot} !==
        {1'b1, 4'd0, 32'hBFC0_0000, 8'd0, 3'd2, 2'b01,
         2'b00, 4'd0, 3'd0}) begin
      n_fail++;
      $display("FAIL inst_ar v=%b id=%h a=%h b=%b exp 1/0/bfc00000/01",
               io_axi_ar_valid, io_axi_ar_id, io_axi_ar_addr,
               io_axi_ar_burst);
    end
    @(negedge clock);
    io_axi_ar_ready = 0; io_axi_r_valid = 1;
    io_axi_r_data = 32'h1234_5678; io_axi_r_last = 1;
    io_axi_r_id = 4'd5; io_axi_r_resp = 2'b10;
    io_inst_r_ready = 1;
    #1;
    n_checks++;
    if ({io_inst_r_valid, io_inst_r_data, io_inst_r_last,
         io_data_r_valid, io_axi_r_ready} !==
        {1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL inst_r v=%b d=%h l=%b dv=%b rr=%b exp 1/12345678/1/0/1",
               io_inst_r_valid, io_inst_r_data, io_inst_r_last,
               io_data_r_valid, io_axi_r_ready);
    end
    @(negedge clock);
    clear_inputs();
    io_axi_r_id = 0; io_axi_r_resp = 0;
    #1;
    n_checks++;
    if ({io_axi_ar_valid, io_axi_r_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL inst_done got=%b exp=00",
               {io_axi_ar_valid, io_axi_r_ready});
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    io_inst_ar_valid = 1; io_inst_ar_addr = 32'h1000_0000;
    io_data_ar_valid = 1; io_data_ar_addr = 32'h2000_0000;
    io_data_ar_len = 0; io_inst_ar_len = 0;
    #1;
    n_checks++;
    if ({io_inst_ar_ready, io_data_ar_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL rr_first got=%b exp=01",
               {io_inst_ar_ready, io_data_ar_ready});
    end
    @(negedge clock);
    io_data_ar_valid = 0; io_axi_ar_ready = 1;
    #1;
    n_checks++;
    if ({io_axi_ar_valid, io_axi_ar_id, io_axi_ar_addr,
         io_inst_ar_ready} !== {1'b1, 4'd1, 32'h2000_0000, 1'b0}) begin
      n_fail++;
      $display("FAIL rr_data_ar v=%b id=%h a=%h ir=%b exp 1/1/20000000/0",
               io_axi_ar_valid, io_axi_ar_id, io_axi_ar_addr,
               io_inst_ar_ready);
    end
    @(negedge clock);
    io_axi_ar_ready = 0; io_axi_r_valid = 1;
    io_axi_r_last = 1; io_axi_r_data = 32'hAAAA_5555;
    io_data_r_ready = 1;
    #1;
    n_checks++;
    if ({io_data_r_valid, io_inst_r_valid, io_inst_ar_ready,
         io_data_r_data} !== {3'b100, 32'hAAAA_5555}) begin
      n_fail++;
      $display("FAIL rr_data_r dv=%b iv=%b ir=%b d=%h exp 1/0/0/aaaa5555",
               io_data_r_valid, io_inst_r_valid, io_inst_ar_ready,
               io_data_r_data);
    end
    @(negedge clock);
    io_axi_r_valid = 0; io_axi_r_last = 0; io_data_r_ready = 0;
    #1;
    n_checks++;
    if (io_inst_ar_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rr_second got=%b exp=1", io_inst_ar_ready);
    end
    @(negedge clock);
    io_inst_ar_valid = 0; io_axi_ar_ready = 1;
    #1;
    n_checks++;
    if ({io_axi_ar_id, io_axi_ar_addr} !== {4'd0, 32'h1000_0000}) begin
      n_fail++;
      $display("FAIL rr_inst_ar id=%h a=%h exp 0/10000000",
               io_axi_ar_id, io_axi_ar_addr);
    end
    @(negedge clock);
    io_axi_ar_ready = 0; io_axi_r_valid = 1; io_axi_r_last = 1;
    io_inst_r_ready = 1;
    @(negedge clock);
    clear_inputs();
  endtask

  task automatic test_write();
    int aw0, w0, wl0, b0;
    aw0 = aw_cnt; w0 = w_cnt; wl0 = wl_cnt; b0 = b_cnt;
    @(negedge clock);
    io_data_aw_valid = 1; io_data_aw_addr = 32'h8000_0100;
    io_data_aw_len = 8'd3; io_data_aw_size = 3'd2;
    #1;
    n_checks++;
    if (io_data_aw_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_aw_ready got=%b exp=1", io_data_aw_ready);
    end
    @(negedge clock);
    io_data_aw_valid = 0;
    @(negedge clock);
    io_axi_aw_ready = 1;
    #1;
    n_checks++;
    if ({io_axi_aw_valid, io_axi_aw_id, io_axi_aw_addr,
         io_axi_aw_len, io_axi_aw_burst, io_axi_aw_lock,
         io_axi_aw_cache, io_axi_aw_prot, io_data_aw_ready} !==
        {1'b1, 4'd1, 32'h8000_0100, 8'd3, 2'b01, 2'b00,
         4'd0, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL wr_aw v=%b id=%h a=%h len=%h exp 1/1/80000100/03",
               io_axi_aw_valid, io_axi_aw_id, io_axi_aw_addr,
               io_axi_aw_len);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      io_axi_aw_ready = 0;
      io_data_w_valid = 1; io_data_w_strb = 4'hF;
      io_data_w_data = 32'hD000_0000 + i;
      io_data_w_last = (i == 3); io_axi_w_ready = 1;
      #1;
      n_checks++;
      if ({io_axi_w_valid, io_data_w_ready, io_axi_w_id,
           io_axi_w_data, io_axi_w_strb, io_axi_w_last} !==
          {2'b11, 4'd1, 32'hD000_0000 + i, 4'hF, (i == 3)}) begin
        n_fail++;
        $display("FAIL wr_beat%0d v=%b r=%b d=%h l=%b", i,
                 io_axi_w_valid, io_data_w_ready, io_axi_w_data,
                 io_axi_w_last);
      end
    end
    @(negedge clock);
    io_data_w_valid = 0; io_data_w_last = 0; io_axi_w_ready = 0;
    io_data_b_ready = 1;
    #1;
    n_checks++;
    if ({io_data_b_valid, io_axi_b_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL wr_b_wait got=%b exp=01",
               {io_data_b_valid, io_axi_b_ready});
    end
    @(negedge clock);
    @(negedge clock);
    io_axi_b_valid = 1;
    #1;
    n_checks++;
    if (io_data_b_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_b_valid got=%b exp=1", io_data_b_valid);
    end
    @(negedge clock);
    clear_inputs();
    #1;
    n_checks++;
    if ({aw_cnt - aw0, w_cnt - w0, wl_cnt - wl0, b_cnt - b0,
         io_data_aw_ready} !== {32'd1, 32'd4, 32'd1, 32'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL wr_counts aw=%0d w=%0d wl=%0d b=%0d exp 1/4/1/1",
               aw_cnt - aw0, w_cnt - w0, wl_cnt - wl0, b_cnt - b0);
    end
  endtask

  task automatic test_read_after_write();
    @(negedge clock);
    io_data_aw_valid = 1; io_data_aw_addr = 32'h8000_0200;
    io_data_aw_len = 0;
    @(negedge clock);
    io_data_aw_valid = 0; io_axi_aw_ready = 1;
    @(negedge clock);
    io_axi_aw_ready = 0;
    io_data_ar_valid = 1; io_data_ar_addr = 32'h8000_0200;
    io_inst_ar_valid = 1; io_inst_ar_addr = 32'h3000_0000;
    #1;
    n_checks++;
    if ({io_inst_ar_ready, io_data_ar_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL raw_grant got=%b exp=10",
               {io_inst_ar_ready, io_data_ar_ready});
    end
    @(negedge clock);
    io_inst_ar_valid = 0; io_axi_ar_ready = 1;
    #1;
    n_checks++;
    if ({io_axi_ar_valid, io_axi_ar_id} !== {1'b1, 4'd0}) begin
      n_fail++;
      $display("FAIL raw_inst_ar v=%b id=%h exp 1/0",
               io_axi_ar_valid, io_axi_ar_id);
    end
    @(negedge clock);
    io_axi_ar_ready = 0; io_axi_r_valid = 1; io_axi_r_last = 1;
    io_inst_r_ready = 1;
    @(negedge clock);
    io_axi_r_valid = 0; io_axi_r_last = 0; io_inst_r_ready = 0;
    io_data_w_valid = 1; io_data_w_last = 1; io_axi_w_ready = 1;
    #1;
    n_checks++;
    if ({io_data_ar_ready, io_axi_ar_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL raw_hold_wdata got=%b exp=00",
               {io_data_ar_ready, io_axi_ar_valid});
    end
    @(negedge clock);
    io_data_w_valid = 0; io_data_w_last = 0; io_axi_w_ready = 0;
    io_axi_b_valid = 1; io_data_b_ready = 1;
    #1;
    n_checks++;
    if ({io_data_ar_ready, io_axi_ar_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL raw_hold_wresp got=%b exp=00",
               {io_data_ar_ready, io_axi_ar_valid});
    end
    @(negedge clock);
    io_axi_b_valid = 0; io_data_b_ready = 0;
    #1;
    n_checks++;
    if (io_data_ar_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL raw_release got=%b exp=1", io_data_ar_ready);
    end
    @(negedge clock);
    io_data_ar_valid = 0; io_axi_ar_ready = 1;
    #1;
    n_checks++;
    if ({io_axi_ar_valid, io_axi_ar_id, io_axi_ar_addr} !==
        {1'b1, 4'd1, 32'h8000_0200}) begin
      n_fail++;
      $display("FAIL raw_data_ar v=%b id=%h a=%h exp 1/1/80000200",
               io_axi_ar_valid, io_axi_ar_id, io_axi_ar_addr);
    end
    @(negedge clock);
    io_axi_ar_ready = 0; io_axi_r_valid = 1; io_axi_r_last = 1;
    io_data_r_ready = 1;
    @(negedge clock);
    clear_inputs();
  endtask

  task automatic test_backpressure();
    int rx, cyc, lows;
    rx = 0; cyc = 0; lows = 0;
    @(negedge clock);
    io_data_ar_valid = 1; io_data_ar_addr = 32'h8000_4000;
    io_data_ar_len = 8'd7;
    @(negedge clock);
    io_data_ar_valid = 0; io_axi_ar_ready = 1;
    #1;
    n_checks++;
    if (io_axi_ar_len !== 8'd7) begin
      n_fail++;
      $display("FAIL bp_len got=%h exp=07", io_axi_ar_len);
    end
    @(negedge clock);
    io_axi_ar_ready = 0;
    while (rx < 8 && cyc < 30) begin
      io_axi_r_valid = 1;
      io_axi_r_data = 32'hC000_0000 + rx;
      io_axi_r_last = (rx == 7);
      io_data_r_ready = !(cyc >= 2 && cyc <= 4);
      #1;
      n_checks++;
      if ({io_axi_r_ready, io_data_r_valid, io_data_r_data} !==
          {io_data_r_ready, 1'b1, 32'hC000_0000 + rx}) begin
        n_fail++;
        $display("FAIL bp_beat%0d rr=%b dv=%b d=%h exp rr=%b", rx,
                 io_axi_r_ready, io_data_r_valid, io_data_r_data,
                 io_data_r_ready);
      end
      if (!io_axi_r_ready) lows++;
      if (io_data_r_ready) rx++;
      cyc++;
      @(negedge clock);
    end
    io_axi_r_valid = 0; io_axi_r_last = 0;
    io_data_r_ready = 1;
    #1;
    n_checks++;
    if ({rx, lows, io_axi_r_ready, io_data_r_valid} !==
        {32'd8, 32'd3, 2'b00}) begin
      n_fail++;
      $display("FAIL bp_summary rx=%0d lows=%0d rr=%b exp 8/3/0",
               rx, lows, io_axi_r_ready);
    end
    clear_inputs();
  endtask

  task automatic test_reset_midburst();
    @(negedge clock);
    io_inst_ar_valid = 1; io_inst_ar_addr = 32'h4000_0000;
    io_inst_ar_len = 8'd3;
    io_data_aw_valid = 1; io_data_aw_len = 8'd3;
    @(negedge clock);
    io_inst_ar_valid = 0; io_data_aw_valid = 0;
    io_axi_ar_ready = 1; io_axi_aw_ready = 1;
    @(negedge clock);
    io_axi_ar_ready = 0; io_axi_aw_ready = 0;
    io_axi_r_valid = 1; io_inst_r_ready = 1;
    io_data_w_valid = 1; io_axi_w_ready = 1;
    #1;
    n_checks++;
    if ({io_inst_r_valid, io_axi_w_valid} !== 2'b11) begin
      n_fail++;
      $display("FAIL rst_pre got=%b exp=11",
               {io_inst_r_valid, io_axi_w_valid});
    end
    reset = 1;
    @(negedge clock);
    #1;
    n_checks++;
    if (w_vr !== 12'h000) begin
      n_fail++;
      $display("FAIL rst_mid_outs got=%h exp=000", w_vr);
    end
    reset = 0;
    #1;
    n_checks++;
    if (w_vr !== 12'b0010_0000_0000) begin
      n_fail++;
      $display("FAIL rst_mid_idle got=%b exp=001000000000", w_vr);
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_inst_read();
    test_round_robin();
    test_write();
    test_read_after_write();
    test_backpressure();
    test_reset_midburst();
    @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_axi_arbiter.md
CACHE_AXI_ARBITER -- requirements
Module: cache_axi_arbiter

Interface
REQ-001 Parameter ID_INST, default 0, SHALL be the AXI id driven on arid for instruction-cache reads.
REQ-002 Parameter ID_DATA, default 1, SHALL be the AXI id driven on arid/awid/wid for data-cache transactions.
REQ-003 clock  in  1  sole clock, all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 io_inst_ar_{valid in 1, ready out 1, addr in 32, len in 8, size in 3}  icache read request.
REQ-006 io_inst_r_{valid out 1, ready in 1, data out 32, last out 1}  icache read data.
REQ-007 io_data_ar_{valid in 1, ready out 1, addr in 32, len in 8, size in 3}  dcache read request.
REQ-008 io_data_r_{valid out 1, ready in 1, data out 32, last out 1}  dcache read data.
REQ-009 io_data_aw_{valid in 1, ready out 1, addr in 32, len in 8, size in 3}  dcache write address.
REQ-010 io_data_w_{valid in 1, ready out 1, data in 32, strb in 4, last in 1}  dcache write data.
REQ-011 io_data_b_{valid out 1, ready in 1}  dcache write response.
REQ-012 io_axi_{ar,r,aw,w,b}_*  AXI3 master port: ar/aw id 4, addr 32, len 8, size 3, burst 2, lock 2, cache 4, prot 3; r id 4, data 32, resp 2, last 1; w id 4, data 32, strb 4, last 1; b id 4, resp 2; valid/ready per channel.

Function
REQ-013 Read FSM SHALL have states R_IDLE, R_ADDR, R_DATA; write FSM SHALL have states W_IDLE, W_ADDR, W_DATA, W_RESP; the two run concurrently.
REQ-014 In R_IDLE with exactly one eligible requester, that requester SHALL be granted; with both eligible, the one not granted last SHALL win (round-robin pointer initialised to favour data).
REQ-015 Data read SHALL be ineligible while write FSM is not W_IDLE (read-after-write ordering).
REQ-016 Grant SHALL assert the winner's ar_ready for exactly one cycle, latch addr/len/size/owner, and enter R_ADDR next cycle.
REQ-017 R_ADDR SHALL drive io_axi_ar_valid=1 from latched fields with arid=owner ID, arburst=2'b01, arlock=0, arcache=0, arprot=0, and move to R_DATA on arready.
REQ-018 R_DATA SHALL route r valid/data/last to the latched owner only, with io_axi_r_ready equal to the owner's r_ready; the non-owner r_valid SHALL be 0.
REQ-019 On rvalid&rready&rlast, read FSM SHALL return to R_IDLE; a new grant SHALL be possible the following cycle (minimum 1 idle cycle between bursts).
REQ-020 W_IDLE SHALL assert io_data_aw_ready; on aw handshake latch fields and enter W_ADDR.
REQ-021 W_ADDR SHALL drive io_axi_aw_valid with awid=ID_DATA, awburst=2'b01, other attributes 0; on awready enter W_DATA.
REQ-022 W_DATA SHALL pass w valid/ready/data/strb/last combinationally between dcache and AXI with wid=ID_DATA; on handshake with wlast enter W_RESP.
REQ-023 W_RESP SHALL set io_axi_b_ready=io_data_b_ready and io_data_b_valid=io_axi_b_valid; on b handshake return to W_IDLE.
REQ-024 rresp/bresp SHALL be ignored; rid/bid SHALL NOT affect routing.
REQ-025 Request-side ready outputs SHALL be 0 outside the states named above.

Reset
REQ-026 Reset SHALL force R_IDLE, W_IDLE, round-robin pointer to data, all latched fields to 0.
REQ-027 While reset is high, every valid output and every ready output SHALL be 0; reset mid-burst SHALL abandon the transaction without completing it.

Structure
REQ-028 State encodings and AXI attribute constants (BURST_INCR, ID widths) SHALL live in the shared package.
REQ-029 Read and write paths SHALL be one module; no sub-module is required.

Verification
REQ-030 Inst read 0xBFC0_0000 len 0, arready immediate, r data 0x1234_5678 last -> arid=0, inst r gets data, data r_valid=0.
REQ-031 Inst and data ar_valid same cycle from reset -> data granted first (arid=1), inst granted after data rlast.
REQ-032 Data write 0x8000_0100 len 3, strb 0xF, 4 beats, bvalid 2 cycles later -> aw once, 4 w beats, wlast on 4th, one data b_valid.
REQ-033 Data ar_valid during W_DATA -> no AXI ar until b handshake; inst ar_valid in same window -> granted.
REQ-034 rready from owner deasserted 3 cycles mid 8-beat burst -> io_axi_r_ready low same cycles, no beat lost or duplicated.
REQ-035 Reset asserted in R_DATA and W_DATA -> next cycle all valid/ready outputs 0, both FSMs idle.
